// File: rtl/pad_poller.sv
// -----------------------------------------------------------------------------
// pad_poller
//   Scans a Mega Drive / Genesis DB9 pad wired directly to the core. TH is
//   driven through the 8-phase 6-button select sequence, the six data lines
//   are sampled at the end of each phase, and the decoded buttons are
//   presented as active-high bits in the order the console I/O port
//   emulation expects.
//
//   Optional build macro: PAD_DEBOUNCE_EN
//     defined     - a scan's result only commits when it equals the result of
//                   the scan before it; the first scan after reset never
//                   commits.
//     not defined - every completed scan commits.
//
// Parameters
//   SETTLE_CYCLES  CE ticks TH is held per phase before sampling (2..255)
//   POLL_CYCLES    CE ticks idle between scans (1..2^20-1); must outlast the
//                  pad's select-counter timeout
//
// Ports
//   CLK      in   core clock
//   RESET    in   synchronous, active-high reset
//   CE       in   clock enable; every counter advances only when CE=1
//   PAD_D    in   [5:0] raw DB9 D0..D5, active low
//   PAD_TH   out  select line to the pad (registered)
//   PAD_TR   out  tied high so the pad keeps TR as an output
//   BTN      out  [11:0] active-high buttons:
//                 [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]A [5]B [6]C [7]START
//                 [8]MODE [9]X [10]Y [11]Z
//   PRESENT  out  Genesis-type pad seen on the last committed scan
//   SIX_BTN  out  6-button pad seen on the last committed scan
//   VALID    out  one-CLK pulse when BTN/PRESENT/SIX_BTN update
// -----------------------------------------------------------------------------
module pad_poller #(
  parameter int SETTLE_CYCLES = 8,
  parameter int POLL_CYCLES   = 16000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [5:0]  PAD_D,
  output logic        PAD_TH,
  output logic        PAD_TR,
  output logic [11:0] BTN,
  output logic        PRESENT,
  output logic        SIX_BTN,
  output logic        VALID
);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [19:0] POLL_LAST   = 20'(POLL_CYCLES - 1);
  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);

  // Apply the pad-type masking to a raw scan result.
  // Returns {six, present, btn[11:0]}.
  function automatic logic [13:0] mask_result(
    input logic [11:0] btn,
    input logic        present,
    input logic        six
  );
    logic [13:0] res;
    if (!present) begin
      res = 14'h0000;
    end else if (!six) begin
      res = {1'b0, 1'b1, 4'h0, btn[7:0]};
    end else begin
      res = {1'b1, 1'b1, btn};
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  phase_q, phase_d;
  logic        th_q, th_d;

  // Scratch collected during a scan, in BTN bit order.
  logic [11:0] scr_btn_q, scr_btn_d;
  logic        scr_present_q, scr_present_d;
  logic        scr_six_q, scr_six_d;

  logic [11:0] btn_q, btn_d;
  logic        present_q, present_d;
  logic        six_q, six_d;
  logic        valid_q, valid_d;

`ifdef PAD_DEBOUNCE_EN
  logic [13:0] prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d;
`endif

  logic [13:0] cand_s;

  // Candidate result built from the completed scratch (ph6 is already
  // registered by the time ph7 ends).
  assign cand_s = mask_result(scr_btn_q, scr_present_q, scr_six_q);

  // Next-state logic: poll timer, phase walk, sampling and commit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    th_d          = th_q;
    scr_btn_d     = scr_btn_q;
    scr_present_d = scr_present_q;
    scr_six_d     = scr_six_q;
    btn_d         = btn_q;
    present_d     = present_q;
    six_d         = six_q;
    valid_d       = 1'b0;
`ifdef PAD_DEBOUNCE_EN
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
`endif

    case (state_q)
      ST_WAIT: begin
        th_d = 1'b1;
        if (CE) begin
          if (cnt_q == POLL_LAST) begin
            state_d = ST_SCAN;
            cnt_d   = 20'd0;
            phase_d = 3'd0;
            th_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_SCAN: begin
        if (CE) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d = 20'd0;

            // Sample the phase that is ending.
            case (phase_q)
              3'd0: begin
                scr_btn_d[3:0] = ~PAD_D[3:0];
                scr_btn_d[5]   = ~PAD_D[4];
                scr_btn_d[6]   = ~PAD_D[5];
              end
              3'd1: begin
                scr_btn_d[4]  = ~PAD_D[4];
                scr_btn_d[7]  = ~PAD_D[5];
                // A Genesis pad grounds D2/D3 while TH is low.
                scr_present_d = (PAD_D[3:2] == 2'b00);
              end
              3'd5: begin
                // Only a 6-button pad drives all four low on the third TH low.
                scr_six_d = (PAD_D[3:0] == 4'b0000);
              end
              3'd6: begin
                scr_btn_d[11] = ~PAD_D[0];
                scr_btn_d[10] = ~PAD_D[1];
                scr_btn_d[9]  = ~PAD_D[2];
                scr_btn_d[8]  = ~PAD_D[3];
              end
              default: begin
                scr_btn_d = scr_btn_q;
              end
            endcase

            if (phase_q == 3'd7) begin
              state_d = ST_WAIT;
              phase_d = 3'd0;
              th_d    = 1'b1;
`ifdef PAD_DEBOUNCE_EN
              prev_d     = cand_s;
              prev_vld_d = 1'b1;
              if (prev_vld_q && (prev_q == cand_s)) begin
                btn_d     = cand_s[11:0];
                present_d = cand_s[12];
                six_d     = cand_s[13];
                valid_d   = 1'b1;
              end else begin
                valid_d = 1'b0;
              end
`else
              btn_d     = cand_s[11:0];
              present_d = cand_s[12];
              six_d     = cand_s[13];
              valid_d   = 1'b1;
`endif
            end else begin
              phase_d = phase_q + 3'd1;
              // Next phase is even (TH high) exactly when this one is odd.
              th_d    = phase_q[0];
            end
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ST_WAIT;
        cnt_d   = 20'd0;
        phase_d = 3'd0;
        th_d    = 1'b1;
      end
    endcase
  end

  // State, scratch and output registers; reset discards any partial scan.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_WAIT;
      cnt_q         <= 20'd0;
      phase_q       <= 3'd0;
      th_q          <= 1'b1;
      scr_btn_q     <= 12'h000;
      scr_present_q <= 1'b0;
      scr_six_q     <= 1'b0;
      btn_q         <= 12'h000;
      present_q     <= 1'b0;
      six_q         <= 1'b0;
      valid_q       <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      prev_q        <= 14'h0000;
      prev_vld_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      th_q          <= th_d;
      scr_btn_q     <= scr_btn_d;
      scr_present_q <= scr_present_d;
      scr_six_q     <= scr_six_d;
      btn_q         <= btn_d;
      present_q     <= present_d;
      six_q         <= six_d;
      valid_q       <= valid_d;
`ifdef PAD_DEBOUNCE_EN
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
`endif
    end
  end

  assign PAD_TH  = th_q;
  assign PAD_TR  = 1'b1;
  assign BTN     = btn_q;
  assign PRESENT = present_q;
  assign SIX_BTN = six_q;
  assign VALID   = valid_q;

endmodule

// File: tb/tb_pad_poller.sv
// -----------------------------------------------------------------------------
// tb_pad_poller
//   Drives pad_poller from a behavioural DB9 pad (3-button, 6-button or
//   unplugged) and compares committed results against a reference derived
//   directly from the pad's pressed buttons.
// -----------------------------------------------------------------------------
module tb_pad_poller;

  localparam int SETTLE = 4;
  localparam int POLL   = 100;
  localparam int PERIOD = POLL + 8 * SETTLE;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CE = 1'b0;
  logic [5:0]  PAD_D;
  logic        PAD_TH;
  logic        PAD_TR;
  logic [11:0] BTN;
  logic        PRESENT;
  logic        SIX_BTN;
  logic        VALID;

  pad_poller #(
    .SETTLE_CYCLES(SETTLE),
    .POLL_CYCLES(POLL)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .CE(CE),
    .PAD_D(PAD_D),
    .PAD_TH(PAD_TH),
    .PAD_TR(PAD_TR),
    .BTN(BTN),
    .PRESENT(PRESENT),
    .SIX_BTN(SIX_BTN),
    .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural pad ----------------
  logic [11:0] pad_btn = 12'h000;
  bit          pad_six = 1'b1;
  bit          pad_conn = 1'b1;
  int          hi_cnt = 0;
  int          low_cnt = 0;

  always @(posedge CLK) hi_cnt <= (PAD_TH === 1'b1) ? hi_cnt + 1 : 0;

  // Pad select counter: restarts after TH has idled high for a long time.
  always @(negedge PAD_TH) low_cnt <= (hi_cnt > 40) ? 1 : low_cnt + 1;

  function automatic logic [5:0] pad_drive(input logic th, input int cnt,
                                           input logic [11:0] b, input bit six,
                                           input bit conn);
    logic [5:0] d;
    if (!conn) d = 6'h3F;
    else if (th) begin
      if (six && cnt == 3) d = {~b[6], ~b[5], ~b[8], ~b[9], ~b[10], ~b[11]};
      else                 d = {~b[6], ~b[5], ~b[3], ~b[2], ~b[1], ~b[0]};
    end else begin
      if (six && cnt == 3)      d = {~b[7], ~b[4], 4'b0000};
      else if (six && cnt == 4) d = {~b[7], ~b[4], 4'b1111};
      else                      d = {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
    end
    return d;
  endfunction

  always_comb PAD_D = pad_drive(PAD_TH, low_cnt, pad_btn, pad_six, pad_conn);

  // Reference: {six, present, btn} a scan of this pad should report.
  function automatic logic [13:0] ref_result(input logic [11:0] b, input bit six,
                                             input bit conn);
    if (!conn) return 14'h0000;
    if (six)   return {1'b1, 1'b1, b};
    return {1'b0, 1'b1, 4'h0, b[7:0]};
  endfunction

  // ---------------- bench infrastructure ----------------
  int checks = 0;
  int errors = 0;
  int ce_div = 1;
  int cyc = 0;
  int ce_ticks = 0;
  int clk_cnt = 0;
  int th_bad = 0;
  logic th_log[$];

  task automatic step();
    logic th_before;
    th_before = PAD_TH;
    CE = (cyc % ce_div == 0);
    cyc++;
    @(posedge CLK);
    #1;
    clk_cnt++;
    if (CE) begin
      ce_ticks++;
      th_log.push_back(PAD_TH);
    end else if (PAD_TH !== th_before) begin
      th_bad++;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    cyc = 0;
    ce_ticks = 0;
    clk_cnt = 0;
    th_log.delete();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (VALID !== 1'b1 && n < budget);
    ok = (VALID === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL valid_timeout: no VALID within %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    checks += 6;
    if (BTN !== 12'h000) begin errors++; $display("FAIL rst_btn: got %h want 000", BTN); end
    if (PRESENT !== 1'b0) begin errors++; $display("FAIL rst_present: got %b want 0", PRESENT); end
    if (SIX_BTN !== 1'b0) begin errors++; $display("FAIL rst_six: got %b want 0", SIX_BTN); end
    if (VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", VALID); end
    if (PAD_TH !== 1'b1) begin errors++; $display("FAIL rst_th: got %b want 1", PAD_TH); end
    if (PAD_TR !== 1'b1) begin errors++; $display("FAIL rst_tr: got %b want 1", PAD_TR); end
  endtask

  task automatic test_six_button();
    bit ok;
    int bad;
    logic exp_th;
    pad_btn = 12'h211; pad_six = 1'b1; pad_conn = 1'b1; ce_div = 1;
    do_reset();
    wait_valid(400, ok);
    checks += 5;
    if (ce_ticks != PERIOD) begin errors++; $display("FAIL first_scan_latency: got %0d want %0d", ce_ticks, PERIOD); end
    if (BTN !== 12'h211) begin errors++; $display("FAIL six_btn: got %h want 211", BTN); end
    if (PRESENT !== 1'b1) begin errors++; $display("FAIL six_present: got %b want 1", PRESENT); end
    if (SIX_BTN !== 1'b1) begin errors++; $display("FAIL six_flag: got %b want 1", SIX_BTN); end
    bad = 0;
    for (int t = 1; t <= th_log.size(); t++) begin
      exp_th = (t >= POLL && t < PERIOD) ? ((((t - POLL) / SETTLE) % 2) == 0) : 1'b1;
      if (th_log[t-1] !== exp_th) bad++;
    end
    if (bad != 0 || th_log.size() != PERIOD) begin
      errors++; $display("FAIL th_trace: %0d wrong of %0d samples, want 0 of %0d", bad, th_log.size(), PERIOD);
    end
    step();
    checks += 2;
    if (VALID !== 1'b0) begin errors++; $display("FAIL valid_width: got %b want 0", VALID); end
    if (BTN !== 12'h211) begin errors++; $display("FAIL six_hold: got %h want 211", BTN); end
  endtask

  task automatic test_three_button();
    bit ok;
    pad_btn = 12'hFC0; pad_six = 1'b0; pad_conn = 1'b1;
    wait_valid(400, ok);
    checks += 3;
    if (BTN !== 12'h0C0) begin errors++; $display("FAIL three_btn: got %h want 0C0", BTN); end
    if (SIX_BTN !== 1'b0) begin errors++; $display("FAIL three_six: got %b want 0", SIX_BTN); end
    if (PRESENT !== 1'b1) begin errors++; $display("FAIL three_present: got %b want 1", PRESENT); end
  endtask

  task automatic test_random();
    bit ok;
    logic [11:0] b;
    logic [13:0] exp_r;
    for (int i = 0; i < 8; i++) begin
      b = 12'($urandom);
      pad_six = ($urandom_range(0, 1) == 1);
      // A 3-button pad with UP+DOWN held is indistinguishable from a 6-button id.
      if (!pad_six && b[0] && b[1]) b[1] = 1'b0;
      pad_btn = b;
      pad_conn = 1'b1;
      exp_r = ref_result(b, pad_six, 1'b1);
      ce_ticks = 0;
      wait_valid(400, ok);
      checks += 2;
      if ({SIX_BTN, PRESENT, BTN} !== exp_r) begin
        errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, {SIX_BTN, PRESENT, BTN}, exp_r);
      end
      if (ce_ticks != PERIOD) begin
        errors++; $display("FAIL rand_period[%0d]: got %0d want %0d", i, ce_ticks, PERIOD);
      end
    end
  endtask

  task automatic test_unconnected();
    bit ok;
    pad_conn = 1'b0;
    wait_valid(400, ok);
    checks++;
    if ({SIX_BTN, PRESENT, BTN} !== 14'h0000) begin
      errors++; $display("FAIL open_first: got %h want 0000", {SIX_BTN, PRESENT, BTN});
    end
    ce_ticks = 0;
    wait_valid(400, ok);
    checks += 2;
    if (ce_ticks != PERIOD) begin errors++; $display("FAIL open_period: got %0d want %0d", ce_ticks, PERIOD); end
    if ({SIX_BTN, PRESENT, BTN} !== 14'h0000) begin
      errors++; $display("FAIL open_second: got %h want 0000", {SIX_BTN, PRESENT, BTN});
    end
    pad_conn = 1'b1;
  endtask

  task automatic test_ce_throttle();
    bit ok;
    pad_btn = 12'h5A3; pad_six = 1'b1; pad_conn = 1'b1; ce_div = 3;
    do_reset();
    th_bad = 0;
    wait_valid(1500, ok);
    clk_cnt = 0;
    wait_valid(1500, ok);
    checks += 3;
    if (clk_cnt != 3 * PERIOD) begin errors++; $display("FAIL ce_period_clks: got %0d want %0d", clk_cnt, 3 * PERIOD); end
    if (BTN !== 12'h5A3) begin errors++; $display("FAIL ce_btn: got %h want 5A3", BTN); end
    if (th_bad != 0) begin errors++; $display("FAIL ce_th_stall: got %0d TH changes on CE=0, want 0", th_bad); end
    ce_div = 1;
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    pad_btn = 12'h0FF; pad_six = 1'b1; pad_conn = 1'b1; ce_div = 1;
    do_reset();
    wait_valid(400, ok);
    checks++;
    if (BTN !== 12'h0FF) begin errors++; $display("FAIL pre_reset_btn: got %h want 0FF", BTN); end
    // Ph3 of the next scan spans CE ticks POLL+12 .. POLL+15 after the commit.
    for (int i = 0; i < POLL + 13; i++) step();
    checks++;
    if (PAD_TH !== 1'b0) begin errors++; $display("FAIL ph3_th: got %b want 0", PAD_TH); end
    RESET = 1'b1;
    step();
    checks += 4;
    if (BTN !== 12'h000) begin errors++; $display("FAIL mid_rst_btn: got %h want 000", BTN); end
    if (PAD_TH !== 1'b1) begin errors++; $display("FAIL mid_rst_th: got %b want 1", PAD_TH); end
    if (VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", VALID); end
    if (PRESENT !== 1'b0) begin errors++; $display("FAIL mid_rst_present: got %b want 0", PRESENT); end
    RESET = 1'b0;
    cyc = 0;
    ce_ticks = 0;
    wait_valid(400, ok);
    checks += 2;
    if (ce_ticks != PERIOD) begin errors++; $display("FAIL post_rst_latency: got %0d want %0d", ce_ticks, PERIOD); end
    if (BTN !== 12'h0FF) begin errors++; $display("FAIL post_rst_btn: got %h want 0FF", BTN); end
  endtask

  initial begin
    test_reset();
    test_six_button();
    test_three_button();
    test_random();
    test_unconnected();
    test_ce_throttle();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_poller.md
Name: pad_poller

Overview:
- Initiator-side controller scanner: drives TH on a physical Mega Drive/Genesis DB9 pad (SNAC-style direct connection) and samples its 6 data lines.
- Walks the 8-phase 6-button select sequence, decodes 3-button and 6-button pads, and presents active-high button bits.
- Output bit order matches what the console-side I/O port emulation consumes as P*_ inputs.
- Sits between the external DB9 pins and the multitap/console I/O emulation.

Parameters:
- SETTLE_CYCLES, 8: CE ticks TH is held per phase before sampling; legal range 2..255.
- POLL_CYCLES, 16000: CE ticks idle between scans; must exceed the pad's ~1.5 ms select-counter timeout at the CE rate; legal range 1..2^20-1.

Ports:
- CLK  in  1  core clock.
- RESET  in  1  synchronous, active-high reset.
- CE  in  1  timing clock-enable; all counters advance only when CE=1.
- PAD_D  in  6  raw DB9 D0..D5, active low: D0 UP, D1 DOWN, D2 LEFT, D3 RIGHT, D4 TL, D5 TR.
- PAD_TH  out  1  select line to pad.
- PAD_TR  out  1  held at 1 (pad output direction); no other function.
- BTN  out  12  active-high: [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]A [5]B [6]C [7]START [8]MODE [9]X [10]Y [11]Z.
- PRESENT  out  1  Genesis-type pad detected on the last scan.
- SIX_BTN  out  1  6-button pad detected on the last scan.
- VALID  out  1  one-CLK pulse when BTN/PRESENT/SIX_BTN update.

Behaviour:
- Reset values: BTN=0, PRESENT=0, SIX_BTN=0, VALID=0, PAD_TH=1, PAD_TR=1; state WAIT with counter cleared.
- A reset asserted mid-scan aborts the scan immediately, leaves outputs at their reset values, and discards any partial sample.
- States: WAIT and SCAN. SCAN has phase index 0..7.
- WAIT:
  - Counts POLL_CYCLES CE ticks with PAD_TH=1.
  - On the tick that completes the count, enters SCAN phase 0.
  - The first scan after reset begins POLL_CYCLES CE ticks after RESET deasserts.
- SCAN timing:
  - PAD_TH=1 in even phases, 0 in odd phases; PAD_TH is registered and changes on entry to a phase.
  - Each phase lasts SETTLE_CYCLES CE ticks.
  - PAD_D is sampled into scratch on the CE tick that ends the phase; that same tick advances the phase.
- Phase decode (scratch registers; "~" = invert):
  - ph0 (TH=1): UP..RIGHT = ~D[3:0], B = ~D4, C = ~D5.
  - ph1 (TH=0): A = ~D4, START = ~D5; present = (D[3:2] == 2'b00).
  - ph2, ph3, ph4: samples ignored.
  - ph5 (TH=0): six = (D[3:0] == 4'b0000).
  - ph6 (TH=1): Z = ~D0, Y = ~D1, X = ~D2, MODE = ~D3.
  - ph7 (TH=0): sample ignored.
- Commit on the CE tick ending ph7:
  - Outputs load atomically, VALID pulses for exactly 1 CLK, PAD_TH returns to 1, state returns to WAIT.
  - If !present: BTN=0 and SIX_BTN=0.
  - If present and !six: BTN[11:8]=0 and SIX_BTN=0.
- Outputs hold between commits. CE low stalls every counter and phase but does not affect held outputs.
- Scan length: 8*SETTLE_CYCLES CE ticks. Period: POLL_CYCLES + 8*SETTLE_CYCLES CE ticks.
- Unconnected port (PAD_D pulled up to 6'h3F): present=0, so all outputs stay 0 with VALID still pulsing every period.

Optional Feature:
- PAD_DEBOUNCE_EN defined:
  - Scratch results from each scan are compared with the previous scan's scratch (BTN, present, six).
  - Outputs commit, and VALID pulses, only when two consecutive scans match.
  - On a mismatch, outputs hold and no VALID pulse is issued.
  - The previous-scan register clears on reset, so the first scan after reset never commits.
- Not defined: every scan commits as described above.

Test Plan:
- 6-button model pressing A+X+UP, SETTLE_CYCLES=4, POLL_CYCLES=100, CE=1 -> after first scan BTN=12'h211, PRESENT=1, SIX_BTN=1, VALID one cycle; PAD_TH trace 1,0,1,0,1,0,1,0 at 4-cycle steps.
- 3-button model (ph5 D[3:0] = current dirs, ph6 repeats ph0) pressing C+START+Z-line-low -> BTN=12'h0C0, SIX_BTN=0, BTN[11:8]=0.
- PAD_D tied 6'h3F -> BTN=0, PRESENT=0, VALID pulses every 132 CE ticks.
- CE asserted 1-in-3 cycles -> identical BTN result; scan length 3x in CLK cycles; PAD_TH never changes on a CE=0 cycle.
- RESET pulsed during ph3 of a scan with prior BTN=12'h0FF -> next cycle BTN=0, PAD_TH=1, no VALID; new scan starts 100 CE ticks later.
- PAD_DEBOUNCE_EN: B pressed on scan 1 only, released scans 2-3 -> no VALID after scans 1 and 2; VALID after scan 3 with BTN=0.
